// File: rtl/bp_update_sched.sv
// Branch predictor update scheduler: queues up to two resolved branches per cycle
// and serialises them as BHT/PHT read-modify-write sequences on a single table port.
module bp_update_sched #(
  parameter int BHT_DEPTH = 10,
  parameter int PHT_DEPTH = 6,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd1_valid,
  input  logic [31:0]          upd1_pc,
  input  logic                 upd1_taken,
  input  logic                 upd2_valid,
  input  logic [31:0]          upd2_pc,
  input  logic                 upd2_taken,
  output logic                 upd_full,
  output logic [BHT_DEPTH-1:0] bht_raddr,
  input  logic [PHT_DEPTH-1:0] bht_rdata,
  output logic [PHT_DEPTH-1:0] pht_raddr,
  input  logic [1:0]           pht_rdata,
  output logic                 bht_we,
  output logic [BHT_DEPTH-1:0] bht_waddr,
  output logic [PHT_DEPTH-1:0] bht_wdata,
  output logic                 pht_we,
  output logic [PHT_DEPTH-1:0] pht_waddr,
  output logic [1:0]           pht_wdata,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);
  localparam int QW = $clog2(QDEPTH);
  localparam int EW = BHT_DEPTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, COMMIT = 2'd2} state_t;

  // 2-bit counter in Gray order: SNT=00, WNT=01, WT=11, ST=10
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
    case (c)
      2'b00:   ctr_next = t ? 2'b01 : 2'b00;
      2'b01:   ctr_next = t ? 2'b11 : 2'b00;
      2'b11:   ctr_next = t ? 2'b10 : 2'b01;
      default: ctr_next = t ? 2'b10 : 2'b11;
    endcase
  endfunction

  logic [EW-1:0]        q_mem [QDEPTH];
  logic [QW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [QW:0]          count_q, count_d, free;
  logic                 acc1, acc2, pop;
  logic [1:0]           n_drop;
  logic [16:0]          drop_sum;
  logic [15:0]          drop_cnt_q;
  state_t               state_q, state_d;
  logic [BHT_DEPTH-1:0] cur_idx_q;
  logic                 cur_taken_q;
  logic [PHT_DEPTH-1:0] hist_q;
  logic [EW-1:0]        ent1, ent2;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{upd1_pc[31:BHT_DEPTH+2], upd1_pc[1:0],
                            upd2_pc[31:BHT_DEPTH+2], upd2_pc[1:0]};

  assign ent1 = {upd1_pc[BHT_DEPTH+1:2], upd1_taken};
  assign ent2 = {upd2_pc[BHT_DEPTH+1:2], upd2_taken};

  // Space is judged on the registered count only, so a same-cycle pop never frees room
  assign free     = (QW+1)'(QDEPTH) - count_q;
  assign acc1     = upd1_valid && (free != '0);
  assign acc2     = upd2_valid && (upd1_valid ? (free >= (QW+1)'(2)) : (free != '0));
  assign n_drop   = {1'b0, upd1_valid & ~acc1} + {1'b0, upd2_valid & ~acc2};
  assign count_d  = count_q + (QW+1)'(acc1) + (QW+1)'(acc2) - (QW+1)'(pop);
  assign drop_sum = {1'b0, drop_cnt_q} + 17'(n_drop);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = COMMIT;
      COMMIT: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc1) q_mem[wr_ptr_q] <= ent1;
    if (acc2) q_mem[wr_ptr_q + QW'(acc1)] <= ent2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      cur_idx_q   <= '0;
      cur_taken_q <= 1'b0;
      hist_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q + QW'(acc1) + QW'(acc2);
      rd_ptr_q   <= rd_ptr_q + QW'(pop);
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (pop) {cur_idx_q, cur_taken_q} <= q_mem[rd_ptr_q];
      if (state_q == LOOKUP) hist_q <= bht_rdata;
    end
  end

  assign upd_full  = free < (QW+1)'(2);
  assign busy      = (count_q != '0) || (state_q != IDLE);
  assign drop_cnt  = drop_cnt_q;
  assign bht_raddr = cur_idx_q;
  assign pht_raddr = hist_q;
  assign bht_we    = (state_q == COMMIT);
  assign pht_we    = (state_q == COMMIT);
  assign bht_waddr = cur_idx_q;
  assign bht_wdata = {hist_q[PHT_DEPTH-2:0], cur_taken_q};
  assign pht_waddr = hist_q;
  assign pht_wdata = ctr_next(pht_rdata, cur_taken_q);

endmodule

// File: tb/tb_bp_update_sched.sv
// Scoreboard bench for bp_update_sched: a behavioural queue/table model predicts every
// table write and status output; a negedge monitor compares them against the DUT.
module tb_bp_update_sched;
  localparam int BD = 10;
  localparam int PD = 6;
  localparam int QD = 4;

  localparam int K_WE = 0, K_BUSY = 1, K_FULL = 2, K_DROP = 3, K_BHT = 4, K_PHT = 5;
  localparam int K_LADDR = 6, K_LPHT = 7, K_LBIT = 8, K_CLR = 9, K_FLAG = 10, K_SBE = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd1_valid = 1'b0, upd1_taken = 1'b0;
  logic          upd2_valid = 1'b0, upd2_taken = 1'b0;
  logic [31:0]   upd1_pc = '0, upd2_pc = '0;
  logic          upd_full, bht_we, pht_we, busy;
  logic [BD-1:0] bht_raddr, bht_waddr;
  logic [PD-1:0] bht_rdata, bht_wdata, pht_raddr, pht_waddr;
  logic [1:0]    pht_rdata, pht_wdata;
  logic [15:0]   drop_cnt;

  logic [PD-1:0] bht_mem [1<<BD];
  logic [1:0]    pht_mem [1<<PD];
  logic [PD-1:0] ref_bht [1<<BD];
  logic [1:0]    ref_pht [1<<PD];

  typedef struct {
    int          at;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } dchk_t;

  logic [BD:0]   mq[$];
  logic [23:0]   exp_q[$];
  logic [23:0]   wlog[$];
  dchk_t         dq[$];
  bit            inflight = 1'b0;
  logic [23:0]   inflight_w = '0;
  int            commit_edge = 0;
  int            engine_free_at = 0;
  int            m_drop = 0;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  bp_update_sched #(.BHT_DEPTH(BD), .PHT_DEPTH(PD), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd2_valid(upd2_valid), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
    .upd_full(upd_full),
    .bht_raddr(bht_raddr), .bht_rdata(bht_rdata),
    .pht_raddr(pht_raddr), .pht_rdata(pht_rdata),
    .bht_we(bht_we), .bht_waddr(bht_waddr), .bht_wdata(bht_wdata),
    .pht_we(pht_we), .pht_waddr(pht_waddr), .pht_wdata(pht_wdata),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  assign bht_rdata = bht_mem[bht_raddr];
  assign pht_rdata = pht_mem[pht_raddr];

  // Counter strength as a level 0..3 (SNT..ST) and its 2-bit encoding
  function automatic int dec(input logic [1:0] c);
    logic [1:0] enc_tab [4];
    enc_tab = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (enc_tab[i] == c) return i;
    return 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    logic [1:0] enc_tab [4];
    enc_tab = '{2'b00, 2'b01, 2'b11, 2'b10};
    return enc_tab[v];
  endfunction

  function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic t);
    int v;
    v = dec(c);
    if (t) v = (v < 3) ? v + 1 : 3;
    else   v = (v > 0) ? v - 1 : 0;
    return enc(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference behaviour at one clock edge, using the inputs held across that edge
  task automatic model_edge();
    int          e, space, drops;
    logic [BD:0] ent;
    logic [PD-1:0] h;
    e = cyc + 1;
    if (inflight && commit_edge == e) begin
      ref_bht[inflight_w[23:14]] = inflight_w[13:8];
      ref_pht[inflight_w[7:2]]   = inflight_w[1:0];
      inflight = 1'b0;
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
      inflight = 1'b0;
      engine_free_at = 0;
      m_drop = 0;
    end else begin
      space = QD - mq.size();
      if (mq.size() > 0 && e >= engine_free_at) begin
        ent = mq.pop_front();
        h = ref_bht[ent[BD:1]];
        inflight_w = {ent[BD:1], h[PD-2:0], ent[0], h, cnt_step(ref_pht[h], ent[0])};
        exp_q.push_back(inflight_w);
        inflight = 1'b1;
        commit_edge = e + 2;
        engine_free_at = e + 2;
      end
      drops = 0;
      if (upd1_valid) begin
        if (space > 0) begin mq.push_back({upd1_pc[BD+1:2], upd1_taken}); space--; end
        else drops++;
      end
      if (upd2_valid) begin
        if (space > 0) begin mq.push_back({upd2_pc[BD+1:2], upd2_taken}); space--; end
        else drops++;
      end
      m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    end
    cyc = e;
  endtask

  task automatic step();
    @(posedge clk);
    if (bht_we) bht_mem[bht_waddr] <= bht_wdata;
    if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v1, input logic [31:0] p1, input logic t1,
                       input logic v2, input logic [31:0] p2, input logic t2);
    upd1_valid = v1; upd1_pc = p1; upd1_taken = t1;
    upd2_valid = v2; upd2_pc = p2; upd2_taken = t2;
  endtask

  task automatic expect_at(input int at, input int kind, input int idx,
                           input logic [31:0] exp, input string name);
    dchk_t d;
    d.at = at; d.kind = kind; d.idx = idx; d.exp = exp; d.name = name;
    dq.push_back(d);
  endtask

  task automatic preset_bht(input int i, input logic [PD-1:0] v);
    bht_mem[i] <= v;
    ref_bht[i] = v;
  endtask

  task automatic preset_pht(input int i, input logic [1:0] v);
    pht_mem[i] <= v;
    ref_pht[i] = v;
  endtask

  function automatic logic [31:0] rpc();
    return ($urandom() & ~32'h0000_0FFC) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 40 && (mq.size() > 0 || inflight); i++) step();
    expect_at(cyc, K_FLAG, int'(mq.size() == 0 && !inflight), 1, "drain_bound");
  endtask

  task automatic rand_step(input bit respect_full);
    logic v1, v2;
    v1 = 1'($urandom_range(0, 1));
    v2 = 1'($urandom_range(0, 1));
    if (respect_full && (QD - mq.size()) < 2) begin v1 = 1'b0; v2 = 1'b0; end
    drive(v1, rpc(), 1'($urandom_range(0, 1)), v2, rpc(), 1'($urandom_range(0, 1)));
    step();
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] got;
    logic [31:0] act;
    logic        m_we;
    int          avail;
    dchk_t       d;
    m_we = inflight && (commit_edge == cyc + 1);
    check("bht_we", 32'(bht_we), 32'(m_we));
    check("pht_we", 32'(pht_we), 32'(m_we));
    check("upd_full", 32'(upd_full), 32'((QD - mq.size()) < 2));
    check("busy", 32'(busy), 32'(mq.size() > 0 || inflight));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (bht_we) begin
      got = {bht_waddr, bht_wdata, pht_waddr, pht_wdata};
      wlog.push_back(got);
      avail = exp_q.size();
      check("write_expected", 32'(avail > 0), 32'd1);
      if (avail > 0) check("write_fields", 32'(got), 32'(exp_q.pop_front()));
    end
    while (dq.size() > 0 && dq[0].at <= cyc) begin
      d = dq.pop_front();
      act = 32'hFFFF_FFFF;
      case (d.kind)
        K_WE:    act = 32'(bht_we);
        K_BUSY:  act = 32'(busy);
        K_FULL:  act = 32'(upd_full);
        K_DROP:  act = 32'(drop_cnt);
        K_BHT:   act = 32'(bht_mem[d.idx]);
        K_PHT:   act = 32'(pht_mem[d.idx]);
        K_LADDR: if (d.idx < wlog.size()) act = 32'(wlog[d.idx][23:14]);
        K_LPHT:  if (d.idx < wlog.size()) act = 32'(wlog[d.idx][1:0]);
        K_LBIT:  if (d.idx < wlog.size()) act = 32'(wlog[d.idx][8]);
        K_FLAG:  act = 32'(d.idx);
        K_SBE:   act = 32'(exp_q.size());
        default: wlog.delete();
      endcase
      if (d.kind != K_CLR) check(d.name, act, d.exp);
    end
  end

  initial begin : stim
    int          c0;
    bit          found;
    logic [31:0] rv;
    for (int i = 0; i < (1 << BD); i++) begin
      rv = $urandom();
      bht_mem[i] <= rv[PD-1:0];
      ref_bht[i] = rv[PD-1:0];
    end
    for (int i = 0; i < (1 << PD); i++) begin
      rv = $urandom();
      pht_mem[i] <= rv[1:0];
      ref_pht[i] = rv[1:0];
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Queue fill from empty with back-to-back dual updates
    c0 = cyc + 1;
    expect_at(c0,     K_FULL, 0, 0, "fill_full_after_2");
    expect_at(c0 + 1, K_FULL, 0, 1, "fill_full_after_3");
    expect_at(c0 + 1, K_DROP, 0, 0, "fill_drop_0");
    expect_at(c0 + 2, K_DROP, 0, 1, "fill_drop_1");
    expect_at(c0 + 3, K_DROP, 0, 3, "fill_drop_3");
    repeat (4) begin
      drive(1, rpc(), 1'($urandom_range(0, 1)), 1, rpc(), 1'($urandom_range(0, 1)));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    wait_idle();

    // Single taken update with known table contents and latency
    preset_bht(4, 6'b000101);
    preset_pht(5, 2'b01);
    c0 = cyc + 1;
    expect_at(c0 + 1, K_WE, 0, 0, "single_we_early");
    expect_at(c0 + 2, K_WE, 0, 1, "single_we_commit");
    expect_at(c0 + 3, K_WE, 0, 0, "single_we_once");
    expect_at(c0 + 4, K_BHT, 4, 32'b001011, "single_bht4");
    expect_at(c0 + 4, K_PHT, 5, 32'b11, "single_pht5");
    drive(1, 32'h0000_0010, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) step();

    // Dual update: slot 1 written first, each slot keeps its own direction
    preset_bht(8, 6'd0);
    preset_bht(9, 6'd0);
    c0 = cyc + 1;
    expect_at(c0, K_CLR, 0, 0, "clr");
    expect_at(c0 + 6, K_LADDR, 0, 8, "dual_first_idx");
    expect_at(c0 + 6, K_LADDR, 1, 9, "dual_second_idx");
    expect_at(c0 + 6, K_LBIT, 0, 0, "dual_slot1_taken");
    expect_at(c0 + 6, K_LBIT, 1, 1, "dual_slot2_taken");
    drive(1, 32'h0000_0020, 0, 1, 32'h0000_0024, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (7) step();

    // Same index twice in one cycle: the second sees the first's history
    preset_bht(16, 6'd0);
    for (int i = 0; i < (1 << PD); i++) preset_pht(i, 2'b00);
    c0 = cyc + 1;
    expect_at(c0 + 6, K_BHT, 16, 32'b000011, "same_bht16");
    expect_at(c0 + 6, K_PHT, 0, 32'b01, "same_pht0");
    expect_at(c0 + 6, K_PHT, 1, 32'b01, "same_pht1");
    drive(1, 32'h0000_0040, 1, 1, 32'h0000_0040, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (7) step();

    // Not-taken sweep from ST through history 0, as a 4-update burst
    preset_bht(32, 6'd0);
    preset_pht(0, 2'b10);
    c0 = cyc + 1;
    expect_at(c0, K_CLR, 0, 0, "clr");
    expect_at(c0 + 8, K_WE, 0, 1, "burst_last_commit");
    expect_at(c0 + 9, K_WE, 0, 0, "burst_done");
    expect_at(c0 + 10, K_LPHT, 0, 32'b11, "sweep_0");
    expect_at(c0 + 10, K_LPHT, 1, 32'b01, "sweep_1");
    expect_at(c0 + 10, K_LPHT, 2, 32'b00, "sweep_2");
    expect_at(c0 + 10, K_LPHT, 3, 32'b00, "sweep_3");
    repeat (4) begin
      drive(1, 32'h0000_0080, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (7) step();

    // Randomised traffic, partly honouring upd_full, partly overrunning it
    for (int i = 0; i < 600; i++) rand_step(i < 300);
    drive(0, 0, 0, 0, 0, 0);
    wait_idle();

    // Reset while the queue is full and a COMMIT is in progress
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive(1, rpc(), 1'($urandom_range(0, 1)), 1, rpc(), 1'($urandom_range(0, 1)));
      step();
      if (inflight && commit_edge == cyc + 1 && mq.size() == QD) found = 1'b1;
    end
    expect_at(cyc, K_FLAG, int'(found), 1, "reach_full_commit");
    rst = 1'b1;
    c0 = cyc + 1;
    expect_at(c0, K_WE, 0, 0, "rst_we");
    expect_at(c0, K_BUSY, 0, 0, "rst_busy");
    expect_at(c0, K_FULL, 0, 0, "rst_full");
    expect_at(c0, K_DROP, 0, 0, "rst_drop");
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    for (int i = 0; i < 100; i++) rand_step(1'b0);
    drive(0, 0, 0, 0, 0, 0);
    wait_idle();
    expect_at(cyc + 1, K_SBE, 0, 0, "scoreboard_empty");
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
